// File: rtl/sumsq_feed_pkg.sv
// Shared types for the CNN normalisation path: feed FSM states and accumulator sizing.
package sumsq_feed_pkg;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        HOLD   = 2'd2,
        LAUNCH = 2'd3
    } feed_state_t;

    // Sum of len squares of data_w-bit signed samples, with headroom so it never wraps.
    function automatic int acc_width(input int data_w, input int len);
        return 2 * data_w + $clog2(len);
    endfunction

endpackage

// File: rtl/sumsq_sat.sv
// Saturating narrow of the accumulated sum to the radicand width, with a clamp flag.
module sumsq_sat #(
    parameter int IN_W  = 20,
    parameter int RAD_W = 16
) (
    input  logic [IN_W-1:0]  x,
    output logic [RAD_W-1:0] rad,
    output logic             sat
);

    generate
        if (IN_W > RAD_W) begin : g_clamp
            assign sat = |x[IN_W-1:RAD_W];
            assign rad = sat ? '1 : x[RAD_W-1:0];
        end else begin : g_pass
            assign sat = 1'b0;
            assign rad = RAD_W'(x);
        end
    endgenerate

endmodule

// File: rtl/sumsq_feed.sv
// Streaming sum-of-squares accumulator that hands a saturated radicand to the sqrt unit.
//   state  | meaning
//   ACCUM  | accepting samples, squaring and accumulating
//   DRAIN  | last square folded in, radicand registered, acc/cnt cleared
//   HOLD   | radicand waiting for sqrt to return the previous root
//   LAUNCH | start pulse to sqrt; first sample of the next vector may be accepted
module sumsq_feed
    import sumsq_feed_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LEN    = 16,
    parameter int RAD_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     sq_start,
    output logic [RAD_W-1:0]         sq_rad,
    input  logic                     sq_valid,
    output logic                     sq_sat,
    output logic                     vec_done
);

    localparam int ACC_W = acc_width(DATA_W, LEN);
    localparam int SQ_W  = 2 * DATA_W;
    localparam int CNT_W = $clog2(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    feed_state_t state, state_nxt;

    logic                   accept;
    logic                   free;
    logic signed [SQ_W-1:0] data_ext;
    logic signed [SQ_W-1:0] prod;
    logic [SQ_W-1:0]        sq_r;
    logic                   sq_v;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_fin;
    logic [CNT_W-1:0]       cnt;
    logic                   pending;
    logic [RAD_W-1:0]       rad_r;
    logic [RAD_W-1:0]       rad_nxt;
    logic                   sat_r;
    logic                   sat_nxt;

    assign accept   = in_valid && in_ready;
    assign free     = !pending || sq_valid;
    assign data_ext = {{DATA_W{in_data[DATA_W-1]}}, in_data};
    assign prod     = data_ext * data_ext;
    // The last square is still in sq_r during DRAIN, so fold it in on the way out.
    assign acc_fin  = acc + ACC_W'(sq_r);

    sumsq_sat #(
        .IN_W  (ACC_W),
        .RAD_W (RAD_W)
    ) u_sat (
        .x   (acc_fin),
        .rad (rad_nxt),
        .sat (sat_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        sq_start  = 1'b0;
        vec_done  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (cnt == CNT_LAST)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = free ? LAUNCH : HOLD;
            end
            HOLD: begin
                if (free) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                in_ready  = 1'b1;
                sq_start  = 1'b1;
                vec_done  = 1'b1;
                state_nxt = ACCUM;
            end
            default: begin
                state_nxt = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_r <= '0;
            sq_v <= 1'b0;
        end else begin
            sq_v <= accept;
            if (accept) begin
                sq_r <= unsigned'(prod);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == DRAIN) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            if (sq_v) begin
                acc <= acc_fin;
            end
            if (accept) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rad_r <= '0;
            sat_r <= 1'b0;
        end else if (state == DRAIN) begin
            rad_r <= rad_nxt;
            sat_r <= sat_nxt;
        end
    end

    // sqrt drops valid the cycle after start, so a high valid outside LAUNCH is a fresh result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (state == LAUNCH) begin
            pending <= 1'b1;
        end else if (sq_valid) begin
            pending <= 1'b0;
        end
    end

    assign sq_rad = rad_r;
    assign sq_sat = sat_r;

endmodule

// File: tb/tb_sumsq_feed.sv
// Randomised bench for sumsq_feed against a vector-level sum-of-squares model and a sqrt stand-in.
module tb_sumsq_feed;

    localparam int DATA_W = 8;
    localparam int LEN    = 4;
    localparam int RAD_W  = 16;
    localparam int RMAX   = (1 << RAD_W) - 1;
    localparam int BIG    = 1 << 30;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     sq_valid = 1'b0;
    logic                     in_ready;
    logic                     sq_start;
    logic [RAD_W-1:0]         sq_rad;
    logic                     sq_sat;
    logic                     vec_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sqrt_lat = 9;
    int sqrt_cnt = 0;
    int rise_cyc = 0;
    int lowrun   = 0;
    int stray_vd = 0;

    typedef struct {
        int rad;
        bit sat;
        int last;
    } exp_t;

    typedef struct {
        int cyc;
        int rad;
        bit sat;
        bit matched;
        int exp_rad;
        bit exp_sat;
        int exp_cyc;
        int low;
        int exp_low;
    } rec_t;

    exp_t exp_q[$];
    rec_t rec_q[$];
    int   part[$];

    sumsq_feed #(
        .DATA_W (DATA_W),
        .LEN    (LEN),
        .RAD_W  (RAD_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .sq_start (sq_start),
        .sq_rad   (sq_rad),
        .sq_valid (sq_valid),
        .sq_sat   (sq_sat),
        .vec_done (vec_done)
    );

    always #5 clk = ~clk;

    // sqrt stand-in: valid low for sqrt_lat cycles after a start, then high until the next start.
    initial begin
        bit st;
        forever begin
            @(negedge clk);
            st = sq_start;
            @(posedge clk);
            #1;
            if (st) begin
                sq_valid = 1'b0;
                sqrt_cnt = sqrt_lat;
            end else if (sqrt_cnt > 0) begin
                sqrt_cnt--;
                if (sqrt_cnt == 0) sq_valid = 1'b1;
            end
        end
    end

    // Reference model: collect accepted samples into vectors, and log every start with its expectation.
    initial begin
        rec_t r;
        exp_t e;
        int   s;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                part.delete();
                exp_q.delete();
                rise_cyc = 0;
                lowrun   = 0;
            end else begin
                if (sq_start) begin
                    r = '{default: 0};
                    r.cyc = cyc;
                    r.rad = int'(sq_rad);
                    r.sat = sq_sat;
                    r.low = lowrun;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        r.matched = 1'b1;
                        r.exp_rad = e.rad;
                        r.exp_sat = e.sat;
                        r.exp_cyc = (e.last + 2 > rise_cyc + 1) ? e.last + 2 : rise_cyc + 1;
                        r.exp_low = r.exp_cyc - e.last - 1;
                    end
                    rec_q.push_back(r);
                    rise_cyc = BIG;
                end else if (sq_valid && rise_cyc == BIG) begin
                    rise_cyc = cyc;
                end
                if (vec_done !== sq_start) stray_vd++;
                lowrun = in_ready ? 0 : lowrun + 1;
                if (in_valid && in_ready) begin
                    part.push_back(int'(in_data));
                    if (part.size() == LEN) begin
                        s = 0;
                        foreach (part[i]) s += part[i] * part[i];
                        e.rad  = (s > RMAX) ? RMAX : s;
                        e.sat  = (s > RMAX);
                        e.last = cyc;
                        exp_q.push_back(e);
                        part.delete();
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic put(input int v, input int gap_max);
        int n;
        bit ok;
        n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (n) begin
            in_valid = 1'b0;
            in_data  = DATA_W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL put_accept: in_ready=0 for 200 cycles, want a transfer");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_recs(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && rec_q.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        ok = (rec_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        total++;
        if (in_ready !== 1'b1 || sq_start !== 1'b0 || vec_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: in_ready=%b sq_start=%b vec_done=%b, want 1 0 0", in_ready, sq_start, vec_done);
        end
        total++;
        if (sq_rad !== '0 || sq_sat !== 1'b0) begin
            bad++;
            $display("FAIL reset_rad: sq_rad=%0d sq_sat=%b, want 0 0", sq_rad, sq_sat);
        end
        rst_n = 1'b1;
        idle(6);
        total++;
        if (rec_q.size() != 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_idle: starts=%0d in_ready=%b, want 0 1", rec_q.size(), in_ready);
        end
    endtask

    task automatic test_basic();
        bit   ok;
        rec_t r;
        put(1, 0); put(2, 0); put(3, 0); put(4, 0);
        in_valid = 1'b0;
        wait_recs(1, 60, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_timeout: starts=%0d, want 1", rec_q.size());
            return;
        end
        r = rec_q.pop_front();
        total++;
        if (r.rad !== 30 || r.sat !== 1'b0 || !r.matched) begin
            bad++;
            $display("FAIL basic_rad: rad=%0d sat=%b, want 30 0", r.rad, r.sat);
        end
        total++;
        if (r.cyc != r.exp_cyc || r.low != 1) begin
            bad++;
            $display("FAIL basic_latency: start cyc=%0d ready_low=%0d, want cyc=%0d ready_low=1", r.cyc, r.low, r.exp_cyc);
        end
    endtask

    task automatic test_saturate();
        bit   ok;
        rec_t r;
        idle(20);
        for (int i = 0; i < LEN; i++) put(-128, 0);
        put(0, 0); put(0, 0); put(0, 0); put(3, 0);
        in_valid = 1'b0;
        wait_recs(2, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL sat_timeout: starts=%0d, want 2", rec_q.size());
            return;
        end
        r = rec_q.pop_front();
        total++;
        if (r.rad !== RMAX || r.sat !== 1'b1 || r.cyc != r.exp_cyc) begin
            bad++;
            $display("FAIL sat_clamp: rad=%0d sat=%b cyc=%0d, want %0d 1 cyc=%0d", r.rad, r.sat, r.cyc, RMAX, r.exp_cyc);
        end
        r = rec_q.pop_front();
        total++;
        if (r.rad !== 9 || r.sat !== 1'b0 || r.cyc != r.exp_cyc || r.low != r.exp_low) begin
            bad++;
            $display("FAIL sat_after: rad=%0d sat=%b cyc=%0d low=%0d, want 9 0 cyc=%0d low=%0d",
                     r.rad, r.sat, r.cyc, r.low, r.exp_cyc, r.exp_low);
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        rec_t r0, r1;
        sqrt_lat = 9;
        idle(20);
        for (int i = 0; i < 2 * LEN; i++) put(int'($urandom_range(255, 0)) - 128, 0);
        in_valid = 1'b0;
        wait_recs(2, 100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL b2b_timeout: starts=%0d, want 2", rec_q.size());
            return;
        end
        r0 = rec_q.pop_front();
        r1 = rec_q.pop_front();
        total++;
        if (!r0.matched || !r1.matched || r0.rad != r0.exp_rad || r1.rad != r1.exp_rad ||
            r0.sat != r0.exp_sat || r1.sat != r1.exp_sat) begin
            bad++;
            $display("FAIL b2b_rad: rad=%0d,%0d sat=%b,%b, want %0d,%0d %b,%b",
                     r0.rad, r1.rad, r0.sat, r1.sat, r0.exp_rad, r1.exp_rad, r0.exp_sat, r1.exp_sat);
        end
        total++;
        if (r1.cyc - r0.cyc != sqrt_lat + 2) begin
            bad++;
            $display("FAIL b2b_hold_release: start spacing=%0d, want %0d", r1.cyc - r0.cyc, sqrt_lat + 2);
        end
        total++;
        if (r1.low != r1.exp_low || r1.cyc != r1.exp_cyc) begin
            bad++;
            $display("FAIL b2b_hold_ready: ready_low=%0d cyc=%0d, want ready_low=%0d cyc=%0d",
                     r1.low, r1.cyc, r1.exp_low, r1.exp_cyc);
        end
    endtask

    task automatic test_gaps();
        bit   ok;
        rec_t r;
        int   nbad;
        sqrt_lat = int'($urandom_range(12, 1));
        idle(20);
        for (int v = 0; v < 3; v++) begin
            put(5, 1); put(-5, 1); put(7, 1); put(-7, 1);
        end
        in_valid = 1'b0;
        wait_recs(3, 200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL gaps_timeout: starts=%0d, want 3", rec_q.size());
            return;
        end
        nbad = 0;
        for (int i = 0; i < 3; i++) begin
            r = rec_q.pop_front();
            if (r.rad !== 148 || r.sat !== 1'b0 || r.cyc != r.exp_cyc || r.low != r.exp_low) begin
                nbad++;
                $display("FAIL gaps_vec%0d: rad=%0d sat=%b cyc=%0d low=%0d, want 148 0 cyc=%0d low=%0d",
                         i, r.rad, r.sat, r.cyc, r.low, r.exp_cyc, r.exp_low);
            end
        end
        total++;
        if (nbad != 0) bad++;
        idle(25);
        total++;
        if (rec_q.size() != 0) begin
            bad++;
            $display("FAIL gaps_extra_start: extra starts=%0d, want 0", rec_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        rec_t r;
        idle(20);
        put(9, 0); put(9, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_ready: in_ready=%b, want 1", in_ready);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        put(2, 0); put(2, 0); put(2, 0); put(2, 0);
        in_valid = 1'b0;
        wait_recs(1, 60, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rstmid_timeout: starts=%0d, want 1", rec_q.size());
            return;
        end
        r = rec_q.pop_front();
        total++;
        if (r.rad !== 16 || r.sat !== 1'b0 || r.cyc != r.exp_cyc) begin
            bad++;
            $display("FAIL rstmid_rad: rad=%0d sat=%b cyc=%0d, want 16 0 cyc=%0d", r.rad, r.sat, r.cyc, r.exp_cyc);
        end
        idle(20);
        total++;
        if (rec_q.size() != 0) begin
            bad++;
            $display("FAIL rstmid_extra_start: extra starts=%0d, want 0", rec_q.size());
        end
    endtask

    task automatic test_reset_hold();
        bit   ok;
        rec_t r;
        sqrt_lat = 9;
        idle(20);
        for (int i = 0; i < LEN; i++) put(1, 0);
        for (int i = 0; i < LEN; i++) put(3, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0 || sq_rad !== 16'd36) begin
            bad++;
            $display("FAIL rsthold_pre: in_ready=%b sq_rad=%0d, want 0 36", in_ready, sq_rad);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || sq_rad !== '0 || sq_sat !== 1'b0 || sq_start !== 1'b0 || vec_done !== 1'b0) begin
            bad++;
            $display("FAIL rsthold_async: in_ready=%b sq_rad=%0d sq_sat=%b sq_start=%b vec_done=%b, want 1 0 0 0 0",
                     in_ready, sq_rad, sq_sat, sq_start, vec_done);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(30);
        wait_recs(1, 1, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rsthold_first: starts=%0d, want 1", rec_q.size());
            return;
        end
        r = rec_q.pop_front();
        total++;
        if (r.rad !== 4 || r.cyc != r.exp_cyc) begin
            bad++;
            $display("FAIL rsthold_first_rad: rad=%0d cyc=%0d, want 4 cyc=%0d", r.rad, r.cyc, r.exp_cyc);
        end
        total++;
        if (rec_q.size() != 0) begin
            bad++;
            $display("FAIL rsthold_held_launched: starts after reset=%0d, want 0", rec_q.size());
        end
    endtask

    task automatic test_random();
        bit   ok;
        rec_t r;
        int   nbad;
        idle(20);
        for (int v = 0; v < 6; v++) begin
            sqrt_lat = int'($urandom_range(12, 1));
            for (int i = 0; i < LEN; i++) begin
                if (v == 3) put(-128, 2);
                else        put(int'($urandom_range(255, 0)) - 128, 2);
            end
        end
        in_valid = 1'b0;
        wait_recs(6, 600, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rand_timeout: starts=%0d, want 6", rec_q.size());
            return;
        end
        nbad = 0;
        for (int i = 0; i < 6; i++) begin
            r = rec_q.pop_front();
            if (!r.matched || r.rad != r.exp_rad || r.sat != r.exp_sat || r.cyc != r.exp_cyc || r.low != r.exp_low) begin
                nbad++;
                $display("FAIL rand_vec%0d: rad=%0d sat=%b cyc=%0d low=%0d, want %0d %b cyc=%0d low=%0d",
                         i, r.rad, r.sat, r.cyc, r.low, r.exp_rad, r.exp_sat, r.exp_cyc, r.exp_low);
            end
        end
        total++;
        if (nbad != 0) bad++;
    endtask

    task automatic test_vec_done();
        total++;
        if (stray_vd != 0) begin
            bad++;
            $display("FAIL vec_done_pulse: cycles with vec_done!=sq_start=%0d, want 0", stray_vd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_reset_hold();
        test_random();
        test_vec_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
